bram_byte_packer: RTL and testbench
===================================

// Module: bram_byte_packer
// PURPOSE
//  Downstream stage of the BRAM read block. Collects the 8-bit data_out/valid byte stream into
//  LANES-byte words and buffers them in a small FIFO. Presents them on a valid/ready interface
//  to the next consumer (DMA / AXI-stream bridge). Upstream has no backpressure, so loss on a
//  full FIFO is detected and flagged, never silent.
// PARAMETERS
//  DATA_W      8   byte width of input stream
//  LANES       4   bytes per output word (>=2)
//  FIFO_DEPTH  4   output word FIFO entries, power of 2, >=2
//  BIG_ENDIAN  0   0: first byte in bits [DATA_W-1:0]; 1: first byte in MSBs
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst        in   1                   asynchronous, active-low reset
//  en         in   1                   1: accept input bytes; 0: ignore in_valid (output side still drains)
//  in_data    in   DATA_W              byte from BRAM read stage
//  in_valid   in   1                   in_data valid this cycle
//  flush      in   1                   push partial word now (end of burst)
//  out_data   out  DATA_W*LANES        packed word, FIFO head
//  out_keep   out  LANES               byte-valid mask of out_data (bit i = lane i)
//  out_valid  out  1                   FIFO non-empty
//  out_ready  in   1                   consumer accepts word when out_valid&out_ready
//  fifo_count out  $clog2(FIFO_DEPTH)+1  words held
//  overflow   out  1                   sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (rst=0, async): lane counter=0, assembly reg=0, FIFO empty.
//   out_valid=0, out_data=0, out_keep=0, fifo_count=0, overflow=0.
//  Byte accept: en&in_valid at edge -> byte written to lane[lane_cnt].
//   lane_cnt increments; wraps LANES-1 -> 0.
//  Word complete: byte written to lane LANES-1 -> word with keep=all-ones is pushed to FIFO on the
//   same edge. Assembly reg is cleared.
//  Latency: FIFO is first-word-fall-through. Last byte at edge N -> out_valid=1 after edge N
//   (visible in cycle N+1) when the FIFO was empty.
//  Flush: at an edge with flush=1:
//   - any same-cycle accepted byte is included first;
//   - then, if lane_cnt (after that byte) >0, the partial word is pushed with keep bits [lane_cnt-1:0]=1
//     and unused lanes zero;
//   - lane_cnt is then reset to 0.
//   A flush with no pending bytes pushes nothing.
//   A flush coinciding with a word completion pushes exactly one full word.
//  Pop: out_valid&out_ready at edge -> head removed.
//   out_data/out_keep show the next entry, or hold 0 when empty.
//  Simultaneous push+pop: allowed in every state, including full; fifo_count unchanged.
//  Full: a push while fifo_count==FIFO_DEPTH with no pop on that edge drops the new word.
//   FIFO contents are unchanged and overflow is set. overflow clears only on reset.
//   Byte assembly continues normally after a drop.
//  Empty: out_ready while out_valid=0 has no effect.
//  en=0: in_valid ignored; lane_cnt/assembly held. flush still honoured.
//  Pointers: log2(FIFO_DEPTH)-bit rd/wr pointers wrap naturally.
//   fifo_count is tracked separately (0..FIFO_DEPTH).
//  Reset mid-operation: all state discarded immediately, including partial words and FIFO contents.
//   No output glitches to valid after rst asserts.
// TESTING
//  T1 Reset: rst=0 for 2 cycles, then rst=1; expect out_valid=0, fifo_count=0, overflow=0, out_data=0.
//  T2 Pack: bytes 11,22,33,44 on 4 consecutive cycles with out_ready=1
//     -> one word 0x44332211, keep=4'b1111, out_valid exactly 1 cycle, after the 4th edge.
//     Same input with BIG_ENDIAN=1 -> 0x11223344.
//  T3 Flush: bytes AA,BB, then flush=1 (no byte) -> word 0x0000BBAA, keep=4'b0011.
//     A 2nd flush with nothing pending -> no push.
//  T4 Overflow: out_ready=0, stream 20 bytes -> fifo_count=4, overflow=1, words 1-4 retained.
//     Then out_ready=1 -> pops exactly those 4 words in order, then out_valid=0.
//  T5 Full push+pop: FIFO full, out_ready=1 while the 4th byte of a new word arrives
//     -> fifo_count stays 4, overflow stays 0, new word is last in order.
//  T6 Async reset mid-word: 3 bytes in, then assert rst between clock edges -> outputs 0 immediately.
//     After release, bytes 01..04 -> 0x04030201 (no stale lanes).

Source files
------------

// File: rtl/bram_byte_packer.sv
// bram_byte_packer: packs a DATA_W-bit byte stream into LANES-byte words and
// buffers them in a first-word-fall-through FIFO with a valid/ready output.
// Upstream has no backpressure, so a word completed while the FIFO is full is
// dropped and the sticky overflow flag is raised.
module bram_byte_packer #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  input  logic                            flush,
  output logic [DATA_W*LANES-1:0]         out_data,
  output logic [LANES-1:0]                out_keep,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int WORD_W = DATA_W * LANES;
  localparam int LANE_W = $clog2(LANES);
  localparam int FILL_W = LANE_W + 1;        // holds 0..LANES
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;         // holds 0..FIFO_DEPTH

  // Assembly state
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;

  // FIFO state
  logic [WORD_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [LANES-1:0]  mem_keep_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  // Per-edge decisions
  logic              accept;
  logic [FILL_W-1:0] fill;       // lanes occupied once this edge's byte lands
  logic [WORD_W-1:0] word_w;     // assembly word including this edge's byte
  logic [LANES-1:0]  keep_w;
  logic              push;
  logic              pop;
  logic              full;
  logic              do_write;

  // Byte assembly: merge the incoming byte, decide whether a word leaves now.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    accept     = en & in_valid;
    word_w     = asm_q;
    fill       = {1'b0, lane_cnt_q};
    keep_w     = '0;
    asm_d      = asm_q;
    lane_cnt_d = lane_cnt_q;

    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (LANE_W'(i) == lane_cnt_q) begin
          word_w[(BIG_ENDIAN ? (LANES - 1 - i) : i) * DATA_W +: DATA_W] = in_data;
        end
      end
      fill = {1'b0, lane_cnt_q} + FILL_W'(1);
    end

    // Keep mask is always lane-indexed, independent of byte order.
    for (int i = 0; i < LANES; i++) begin
      keep_w[i] = (FILL_W'(i) < fill);
    end

    // A full word and a flush on the same edge still push exactly one word.
    push = (fill == FILL_W'(LANES)) || (flush && (fill != '0));

    if (push || flush) begin
      asm_d      = '0;
      lane_cnt_d = '0;
    end else begin
      asm_d      = word_w;
      lane_cnt_d = fill[LANE_W-1:0];
    end
  end

  // FIFO control: push/pop bookkeeping, drop-on-full and sticky overflow.
  always_comb begin
    out_valid  = (count_q != '0);
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = out_valid & out_ready;
    // A pop on the same edge frees the head slot, so a push into a full FIFO
    // lands where the old head was and becomes the newest entry.
    do_write   = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({do_write, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and assembly registers, discarded immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      lane_cnt_q <= lane_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; entries are only
  // observable through count_q, which is reset, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_data_q[wr_ptr_q] <= word_w;
      mem_keep_q[wr_ptr_q] <= keep_w;
    end
  end

  // First-word-fall-through head, forced to zero while empty.
  always_comb begin
    out_data = out_valid ? mem_data_q[rd_ptr_q] : '0;
    out_keep = out_valid ? mem_keep_q[rd_ptr_q] : '0;
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bram_byte_packer.sv
// Self-checking bench for bram_byte_packer. Two instances (little- and
// big-endian) share all inputs; a queue-based model of the byte stream and
// word FIFO predicts both, and a compare process checks every cycle.
module tb_bram_byte_packer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;

  logic [DW*L-1:0] le_data, be_data;
  logic [L-1:0]    le_keep, be_keep;
  logic            le_valid, be_valid, le_ovf, be_ovf;
  logic [2:0]      le_cnt, be_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_byte_packer #(.DATA_W(DW), .LANES(L), .FIFO_DEPTH(D), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .out_data(le_data), .out_keep(le_keep), .out_valid(le_valid),
    .out_ready(out_ready), .fifo_count(le_cnt), .overflow(le_ovf)
  );

  bram_byte_packer #(.DATA_W(DW), .LANES(L), .FIFO_DEPTH(D), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .out_data(be_data), .out_keep(be_keep), .out_valid(be_valid),
    .out_ready(out_ready), .fifo_count(be_cnt), .overflow(be_ovf)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW*L-1:0] le;
    logic [DW*L-1:0] be;
    logic [L-1:0]    keep;
  } word_t;

  logic [DW-1:0] pend[$];
  word_t         words[$];
  bit            m_ovf = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend.delete();
        words.delete();
        m_ovf = 1'b0;
      end else begin
        bit    popped;
        bit    have;
        word_t w;
        popped = (words.size() > 0) && out_ready;
        have   = 1'b0;
        if (en && in_valid) pend.push_back(in_data);
        if (pend.size() == L || (flush && pend.size() > 0)) begin
          w.le = '0; w.be = '0; w.keep = '0;
          for (int k = 0; k < pend.size(); k++) begin
            w.le[k*DW +: DW]         = pend[k];
            w.be[(L-1-k)*DW +: DW]   = pend[k];
            w.keep[k]                = 1'b1;
          end
          pend.delete();
          have = 1'b1;
        end
        if (popped) void'(words.pop_front());
        if (have) begin
          if (words.size() < D) words.push_back(w);
          else                  m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [DW*L-1:0] e_le, e_be;
        logic [L-1:0]    e_keep;
        e_le   = (words.size() > 0) ? words[0].le   : '0;
        e_be   = (words.size() > 0) ? words[0].be   : '0;
        e_keep = (words.size() > 0) ? words[0].keep : '0;
        check("le_valid", 64'(le_valid), 64'(words.size() > 0));
        check("le_count", 64'(le_cnt),   64'(words.size()));
        check("le_ovf",   64'(le_ovf),   64'(m_ovf));
        check("le_data",  64'(le_data),  64'(e_le));
        check("le_keep",  64'(le_keep),  64'(e_keep));
        check("be_valid", 64'(be_valid), 64'(words.size() > 0));
        check("be_count", 64'(be_cnt),   64'(words.size()));
        check("be_data",  64'(be_data),  64'(e_be));
        check("be_keep",  64'(be_keep),  64'(e_keep));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge: apply inputs, return at the next falling edge.
  task automatic drive(input logic e, input logic v, input logic [DW-1:0] d,
                       input logic f, input logic r);
    en = e; in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
  endtask

  task automatic put(input logic [DW-1:0] d, input logic r);
    drive(1'b1, 1'b1, d, 1'b0, r);
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 1'b0, '0, 1'b0, r);
  endtask

  initial begin
    logic [31:0] exp_words [4];
    exp_words[0] = 32'h04030201; exp_words[1] = 32'h08070605;
    exp_words[2] = 32'h0C0B0A09; exp_words[3] = 32'h100F0E0D;

    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // T1 reset
    @(negedge clk); @(negedge clk);
    check("t1_valid", 64'(le_valid), 64'd0);
    check("t1_count", 64'(le_cnt),   64'd0);
    check("t1_ovf",   64'(le_ovf),   64'd0);
    check("t1_data",  64'(le_data),  64'd0);
    rst = 1'b1;
    idle(1'b1);

    // T2 pack, both byte orders, valid for exactly one cycle
    put(8'h11, 1'b1); put(8'h22, 1'b1); put(8'h33, 1'b1);
    check("t2_not_yet", 64'(le_valid), 64'd0);
    put(8'h44, 1'b1);
    check("t2_valid", 64'(le_valid), 64'd1);
    check("t2_le",    64'(le_data),  64'h44332211);
    check("t2_be",    64'(be_data),  64'h11223344);
    check("t2_keep",  64'(le_keep),  64'hF);
    idle(1'b1);
    check("t2_one_cycle", 64'(le_valid), 64'd0);

    // T3 partial flush, with a byte offered while disabled
    put(8'hAA, 1'b0);
    drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    put(8'hBB, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t3_le",    64'(le_data), 64'h0000BBAA);
    check("t3_be",    64'(be_data), 64'hAABB0000);
    check("t3_keep",  64'(le_keep), 64'h3);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("t3_no_push", 64'(le_cnt), 64'd1);
    idle(1'b1);
    check("t3_drained", 64'(le_cnt), 64'd0);

    // T4 overflow: 20 bytes into a 4-word FIFO with no consumer
    for (int i = 1; i <= 20; i++) put(8'(i), 1'b0);
    check("t4_count", 64'(le_cnt), 64'd4);
    check("t4_ovf",   64'(le_ovf), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_head%0d", i), 64'(le_data), 64'(exp_words[i]));
      idle(1'b1);
    end
    check("t4_empty", 64'(le_valid), 64'd0);
    check("t4_sticky", 64'(le_ovf), 64'd1);
    rst = 1'b0; idle(1'b0); rst = 1'b1;
    check("t4_ovf_clr", 64'(le_ovf), 64'd0);

    // T5 push and pop on the same edge while full
    for (int i = 0; i < 16; i++) put(8'(8'h20 + i), 1'b0);
    put(8'h30, 1'b0); put(8'h31, 1'b0); put(8'h32, 1'b0);
    check("t5_full", 64'(le_cnt), 64'd4);
    put(8'h33, 1'b1);
    check("t5_count", 64'(le_cnt),  64'd4);
    check("t5_ovf",   64'(le_ovf),  64'd0);
    check("t5_head",  64'(le_data), 64'h27262524);
    idle(1'b1); idle(1'b1); idle(1'b1);
    check("t5_last",  64'(le_data), 64'h33323130);
    check("t5_left",  64'(le_cnt),  64'd1);
    idle(1'b1);

    // T6 asynchronous reset mid-word with a word already queued
    put(8'h51, 1'b0); put(8'h52, 1'b0); put(8'h53, 1'b0); put(8'h54, 1'b0);
    put(8'hA1, 1'b0); put(8'hA2, 1'b0); put(8'hA3, 1'b0);
    check("t6_queued", 64'(le_cnt), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_valid", 64'(le_valid), 64'd0);
    check("t6_data",  64'(le_data),  64'd0);
    check("t6_count", 64'(le_cnt),   64'd0);
    check("t6_keep",  64'(le_keep),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b0); put(8'h04, 1'b0);
    check("t6_fresh", 64'(le_data), 64'h04030201);
    check("t6_count1", 64'(le_cnt), 64'd1);
    idle(1'b1); idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
